// File: rtl/video_pkg.sv
// Shared types and constants for the run-length-encoded pixel path.
// Runs carry (colour, length) where length N means N+1 pixels.
package video_pkg;

  localparam int COLOUR_W = 6;
  localparam int LEN_W    = 10;
  localparam int LINE_W   = 10;

  localparam logic [COLOUR_W-1:0] UNDERRUN_COLOUR = 6'h30;
  localparam logic [LEN_W:0]      CNT_ONE         = (LEN_W+1)'(1);
  localparam logic [LINE_W-1:0]   LINE_MAX        = '1;

  typedef struct packed {
    logic [COLOUR_W-1:0] colour;
    logic [LEN_W-1:0]    length;
  } rle_run_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  // Widened by one bit so a length field of all ones becomes 2**LEN_W pixels.
  function automatic logic [LEN_W:0] run_pixels(input logic [LEN_W-1:0] length);
    return {1'b0, length} + CNT_ONE;
  endfunction

endpackage

// File: rtl/rle_run_slot.sv
// One run register: colour plus remaining pixel count (0 = empty).
// Priority is clear, then load, then decrement.
module rle_run_slot
  import video_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_clear,
  input  logic                i_load,
  input  logic                i_dec,
  input  logic [COLOUR_W-1:0] i_colour,
  input  logic [LEN_W:0]      i_cnt,
  output logic [COLOUR_W-1:0] o_colour,
  output logic [LEN_W:0]      o_cnt,
  output logic                o_empty
);

  logic [COLOUR_W-1:0] r_colour;
  logic [LEN_W:0]      r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_colour <= '0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_colour <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_colour <= i_colour;
      r_cnt    <= i_cnt;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_colour = r_colour;
  assign o_cnt    = r_cnt;
  assign o_empty  = (r_cnt == '0);

endmodule

// File: rtl/rle_run_sequencer.sv
// Turns (colour, length) runs into a registered pixel stream paced by blank,
// with a current run plus one prefetch entry, frame restart and error flags.
module rle_run_sequencer
  import video_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                blank,
  input  logic                vsync_pulse,
  input  logic                hsync_pulse,
  input  logic                run_valid,
  input  logic [COLOUR_W-1:0] run_colour,
  input  logic [LEN_W-1:0]    run_length,
  output logic                run_ready,
  output logic                stream_restart,
  output logic [COLOUR_W-1:0] colour,
  output logic                underrun,
  output logic                runs_left,
  output logic [LINE_W-1:0]   line_count
);

  seq_state_e r_state;
  seq_state_e w_next_state;

  logic [COLOUR_W-1:0] r_colour;
  logic                r_restart;
  logic                r_underrun;
  logic                r_runs_left;
  logic [LINE_W-1:0]   r_line_count;

  rle_run_t            w_offer;
  logic [COLOUR_W-1:0] w_cur_col;
  logic [LEN_W:0]      w_cur_cnt;
  logic                w_cur_empty;
  logic [COLOUR_W-1:0] w_pre_col;
  logic [LEN_W:0]      w_pre_cnt;
  logic                w_pre_empty;
  logic                w_pre_valid;

  logic                w_run_mode;
  logic                w_frame_end;
  logic                w_accept;
  logic                w_pixel;
  logic                w_cur_free;
  logic                w_flush;
  logic                w_promote;
  logic                w_cur_load;
  logic                w_pre_load;
  logic [COLOUR_W-1:0] w_cur_src_col;
  logic [LEN_W:0]      w_cur_src_cnt;

  assign w_offer     = '{colour: run_colour, length: run_length};
  assign w_pre_valid = !w_pre_empty;

  assign w_run_mode  = (r_state == RUN) && enable;
  assign w_frame_end = w_run_mode && vsync_pulse;
  assign w_accept    = run_valid && run_ready;
  assign w_pixel     = w_run_mode && !vsync_pulse && !blank && !w_cur_empty;

  // Cur can take a new run this cycle if it is empty or is emitting its last pixel.
  assign w_cur_free  = w_cur_empty || ((w_cur_cnt == CNT_ONE) && w_pixel);
  assign w_flush     = !enable || w_frame_end;
  assign w_promote   = w_cur_free && w_pre_valid;
  assign w_cur_load  = w_promote || (w_cur_free && w_accept);
  assign w_pre_load  = w_accept && !w_cur_free;

  assign w_cur_src_col = w_pre_valid ? w_pre_col : w_offer.colour;
  assign w_cur_src_cnt = w_pre_valid ? w_pre_cnt : run_pixels(w_offer.length);

  rle_run_slot u_cur (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_flush),
    .i_load   (w_cur_load),
    .i_dec    (w_pixel),
    .i_colour (w_cur_src_col),
    .i_cnt    (w_cur_src_cnt),
    .o_colour (w_cur_col),
    .o_cnt    (w_cur_cnt),
    .o_empty  (w_cur_empty)
  );

  rle_run_slot u_pre (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_flush || w_promote),
    .i_load   (w_pre_load),
    .i_dec    (1'b0),
    .i_colour (w_offer.colour),
    .i_cnt    (run_pixels(w_offer.length)),
    .o_colour (w_pre_col),
    .o_cnt    (w_pre_cnt),
    .o_empty  (w_pre_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (enable && vsync_pulse) w_next_state = RUN;
      RUN:  if (!enable)               w_next_state = IDLE;
      default:                         w_next_state = IDLE;
    endcase
  end

  always_comb begin
    run_ready = 1'b0;
    if (r_state == RUN) run_ready = !w_pre_valid && !vsync_pulse;
  end

  // Pixel, flag and line-counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_colour     <= '0;
      r_restart    <= 1'b0;
      r_underrun   <= 1'b0;
      r_runs_left  <= 1'b0;
      r_line_count <= '0;
    end else begin
      r_restart <= 1'b0;

      if (vsync_pulse)                                   r_line_count <= '0;
      else if (hsync_pulse && (r_line_count != LINE_MAX)) r_line_count <= r_line_count + 1'b1;

      if (r_state == IDLE) begin
        r_colour <= '0;
        if (enable && vsync_pulse) r_restart <= 1'b1;
      end else if (!enable) begin
        r_colour <= '0;
      end else if (vsync_pulse) begin
        // Frame end overrides a coincident visible pixel.
        r_colour    <= '0;
        r_restart   <= 1'b1;
        r_underrun  <= 1'b0;
        r_runs_left <= !w_cur_empty || w_pre_valid;
      end else if (blank) begin
        r_colour <= '0;
      end else if (!w_cur_empty) begin
        r_colour <= w_cur_col;
      end else begin
        r_colour   <= UNDERRUN_COLOUR;
        r_underrun <= 1'b1;
      end
    end
  end

  assign colour         = r_colour;
  assign stream_restart = r_restart;
  assign underrun       = r_underrun;
  assign runs_left      = r_runs_left;
  assign line_count     = r_line_count;

endmodule

// File: tb/tb_rle_run_sequencer.sv
// Directed and randomized bench for rle_run_sequencer against a queue-based
// model: the sequencer holds at most two runs, consumed front-first.
module tb_rle_run_sequencer;
  import video_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                enable;
  logic                blank;
  logic                vsync_pulse;
  logic                hsync_pulse;
  logic                run_valid;
  logic [COLOUR_W-1:0] run_colour;
  logic [LEN_W-1:0]    run_length;
  logic                run_ready;
  logic                stream_restart;
  logic [COLOUR_W-1:0] colour;
  logic                underrun;
  logic                runs_left;
  logic [LINE_W-1:0]   line_count;

  rle_run_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .blank          (blank),
    .vsync_pulse    (vsync_pulse),
    .hsync_pulse    (hsync_pulse),
    .run_valid      (run_valid),
    .run_colour     (run_colour),
    .run_length     (run_length),
    .run_ready      (run_ready),
    .stream_restart (stream_restart),
    .colour         (colour),
    .underrun       (underrun),
    .runs_left      (runs_left),
    .line_count     (line_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [COLOUR_W-1:0] col;
    int                  rem;
  } mrun_t;

  mrun_t               q[$];
  bit                  m_running;
  logic [COLOUR_W-1:0] m_colour;
  bit                  m_restart;
  bit                  m_underrun;
  bit                  m_runs_left;
  int                  m_line;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return m_running && (q.size() < 2) && !vsync_pulse;
  endfunction

  task automatic model_edge();
    bit    rdy;
    mrun_t head;
    rdy = m_ready();
    if (!reset_n) begin
      q.delete();
      m_running = 0; m_colour = '0; m_restart = 0;
      m_underrun = 0; m_runs_left = 0; m_line = 0;
      return;
    end
    m_restart = 0;
    if (vsync_pulse) m_line = 0;
    else if (hsync_pulse && m_line < 1023) m_line++;
    if (!m_running) begin
      m_colour = '0;
      if (enable && vsync_pulse) begin
        m_running = 1;
        m_restart = 1;
      end
    end else if (!enable) begin
      m_running = 0;
      q.delete();
      m_colour = '0;
    end else if (vsync_pulse) begin
      m_runs_left = (q.size() != 0);
      q.delete();
      m_underrun = 0;
      m_restart  = 1;
      m_colour   = '0;
    end else begin
      if (blank) begin
        m_colour = '0;
      end else if (q.size() != 0) begin
        head     = q[0];
        m_colour = head.col;
        head.rem--;
        if (head.rem == 0) void'(q.pop_front());
        else               q[0] = head;
      end else begin
        m_colour   = UNDERRUN_COLOUR;
        m_underrun = 1;
      end
      if (run_valid && rdy) q.push_back('{run_colour, int'(run_length) + 1});
    end
  endtask

  // One clock: check run_ready before the edge, advance model, check outputs after.
  task automatic cycle();
    #1;
    check("run_ready", run_ready, m_ready());
    model_edge();
    @(posedge clk);
    #1;
    check("colour", colour, m_colour);
    check("stream_restart", stream_restart, m_restart);
    check("underrun", underrun, m_underrun);
    check("runs_left", runs_left, m_runs_left);
    check("line_count", line_count, m_line);
  endtask

  task automatic drive(input bit en, input bit bl, input bit vs, input bit hs,
                       input bit rv, input logic [COLOUR_W-1:0] col,
                       input logic [LEN_W-1:0] len);
    enable = en; blank = bl; vsync_pulse = vs; hsync_pulse = hs;
    run_valid = rv; run_colour = col; run_length = len;
  endtask

  int vis;
  int seen;

  initial begin
    reset_n = 1'b0;
    drive(0, 1, 0, 0, 0, '0, '0);
    @(posedge clk); #1;
    cycle();
    cycle();
    check("reset_colour", colour, 0);
    check("reset_ready", run_ready, 0);
    reset_n = 1'b1;

    // Back-to-back single-pixel runs after a priming blank cycle.
    drive(1, 1, 1, 0, 0, '0, '0); cycle();
    check("start_restart", stream_restart, 1);
    drive(1, 1, 0, 0, 1, 6'h3F, 10'd0); cycle();
    drive(1, 0, 0, 0, 1, 6'h0C, 10'd0); cycle();
    check("b2b_0", colour, 6'h3F);
    drive(1, 0, 0, 0, 1, 6'h03, 10'd0); cycle();
    check("b2b_1", colour, 6'h0C);
    drive(1, 0, 0, 0, 0, '0, '0); #1;
    check("b2b_ready", run_ready, 1);
    cycle();
    check("b2b_2", colour, 6'h03);
    check("b2b_no_underrun", underrun, 0);

    // Ten-pixel run spanning a blank gap, then underrun.
    drive(1, 1, 1, 0, 0, '0, '0); cycle();
    drive(1, 1, 0, 0, 1, 6'h15, 10'd9); cycle();
    seen = 0; vis = 0;
    for (int i = 0; i < 14; i++) begin
      drive(1, (i >= 4 && i < 7), 0, 0, 0, '0, '0);
      cycle();
      if (!blank) begin
        vis++;
        if (vis <= 10 && colour == 6'h15) seen++;
      end
    end
    check("gap_pixels", seen, 10);
    check("gap_underrun_colour", colour, 6'h30);
    check("gap_underrun_flag", underrun, 1);

    // Longest run: 10'h3FF gives 1024 pixels.
    drive(1, 1, 1, 0, 0, '0, '0); cycle();
    check("vsync_clears_underrun", underrun, 0);
    drive(1, 1, 0, 0, 1, 6'h2A, 10'h3FF); cycle();
    seen = 0;
    for (int i = 0; i < 1025; i++) begin
      drive(1, 0, 0, 0, 0, '0, '0);
      cycle();
      if (colour == 6'h2A) seen++;
    end
    check("max_run_pixels", seen, 1024);
    check("max_run_then_underrun", colour, 6'h30);

    // vsync with prefetch loaded and run_valid offered.
    drive(1, 1, 0, 1, 1, 6'h11, 10'd5); cycle();
    drive(1, 1, 0, 0, 1, 6'h22, 10'd0); cycle();
    drive(1, 1, 0, 0, 1, 6'h33, 10'd0); #1;
    check("prefetch_full_ready", run_ready, 0);
    cycle();
    drive(1, 1, 1, 0, 1, 6'h33, 10'd0); #1;
    check("vsync_ready", run_ready, 0);
    cycle();
    check("vsync_runs_left", runs_left, 1);
    check("vsync_restart", stream_restart, 1);
    check("vsync_underrun", underrun, 0);
    check("vsync_line", line_count, 0);
    drive(1, 0, 0, 0, 0, '0, '0); cycle();
    check("restart_one_cycle", stream_restart, 0);
    check("vsync_no_handshake", colour, 6'h30);

    // Reset with cur=5 pixels and prefetch valid.
    drive(1, 1, 1, 0, 0, '0, '0); cycle();
    drive(1, 1, 0, 0, 1, 6'h05, 10'd4); cycle();
    drive(1, 1, 0, 0, 1, 6'h06, 10'd0); cycle();
    reset_n = 1'b0;
    drive(1, 0, 0, 0, 0, '0, '0); cycle();
    check("rst_colour", colour, 0);
    check("rst_runs_left", runs_left, 0);
    check("rst_underrun", underrun, 0);
    reset_n = 1'b1;
    #1;
    check("rst_ready", run_ready, 0);
    cycle();
    check("rst_idle_colour", colour, 0);

    // Disable mid-frame, then re-enable and restart on vsync.
    drive(1, 1, 1, 0, 0, '0, '0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 1, 6'h09, 10'd2); cycle();
    end
    check("hsync_count", line_count, 3);
    drive(0, 0, 0, 0, 0, '0, '0); cycle();
    check("disable_colour", colour, 0);
    check("disable_line", line_count, 3);
    drive(1, 0, 0, 0, 1, 6'h09, 10'd0); #1;
    check("disabled_ready", run_ready, 0);
    cycle();
    check("idle_colour", colour, 0);
    drive(1, 1, 1, 0, 0, '0, '0); cycle();
    check("reenable_restart", stream_restart, 1);

    // Line counter saturation and vsync priority over hsync.
    for (int i = 0; i < 1030; i++) begin
      drive(1, 1, 0, 1, 0, '0, '0); cycle();
    end
    check("line_saturate", line_count, 1023);
    drive(1, 1, 1, 1, 0, '0, '0); cycle();
    check("line_vsync_wins", line_count, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 2) == 0),
            ((i % 250) == 249) || ($urandom_range(0, 299) == 0),
            ($urandom_range(0, 19) == 0),
            $urandom_range(0, 1),
            COLOUR_W'($urandom),
            ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(0, 40))
                                        : LEN_W'($urandom_range(0, 2)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
